// File: rtl/comp_capture_pkg.sv
// Shared types and defaults for the comparator event counter / serial readout.
package comp_capture_pkg;

    localparam int N_CH_DEF  = 8;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int bcnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/comp_sync.sv
// Per-channel 2-flop synchronizer and rising-edge detector.
// With COMP_GLITCH_FILTER_EN a stability stage drops single-cycle pulses (+1 cycle latency).
module comp_sync
    import comp_capture_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic comp,
    output logic rise
);

    logic s1, s2, prev;

`ifdef COMP_GLITCH_FILTER_EN
    logic s3, filt;

    // A synchronized value is accepted once it has been seen on two consecutive cycles.
    assign filt = (s2 == s3) ? s2 : prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= comp;
            s2   <= s1;
            s3   <= s2;
            prev <= filt;
        end
    end

    assign rise = filt & ~prev;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= comp;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign rise = s2 & ~prev;
`endif

endmodule

// File: rtl/comp_capture.sv
// Comparator bank event counters with snapshot-and-clear and MSB-first serial readout.
// Optional glitch filter in the synchronizers: define COMP_GLITCH_FILTER_EN.
module comp_capture
    import comp_capture_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic [N_CH-1:0] comp_i,
    input  logic            en_i,
    input  logic            start_i,
    output logic            sdo_o,
    output logic            sdo_valid_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            ovf_o
);

    localparam int TOT = N_CH * CNT_W;
    localparam int BW  = bcnt_w(TOT);
    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

    logic [N_CH-1:0]             rise;
    logic [N_CH-1:0][CNT_W-1:0]  cnt;
    logic [N_CH-1:0]             sat;
    logic [TOT-1:0]              flat;
    logic [TOT-1:0]              shadow;
    logic [BW-1:0]               bitcnt;
    state_t                      state;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        comp_sync u_sync (
            .clk  (wb_clk_i),
            .rst  (wb_rst_i),
            .comp (comp_i[g]),
            .rise (rise[g])
        );
    end

    // Channel N_CH-1 lands in the top bits, so a left shift gives the readout order.
    assign flat = cnt;

    // An edge arriving in LOAD is the first event of the new window.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt <= '0;
            sat <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (state == LOAD) begin
                    cnt[i] <= (rise[i] && en_i) ? CNT_W'(1) : '0;
                    sat[i] <= 1'b0;
                end else if (rise[i] && en_i && cnt[i] != CMAX) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                    if (cnt[i] == CMAX - CNT_W'(1))
                        sat[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            shadow      <= '0;
            bitcnt      <= '0;
            sdo_o       <= 1'b0;
            sdo_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            ovf_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        state  <= LOAD;
                        busy_o <= 1'b1;
                    end
                end
                LOAD: begin
                    // First bit goes straight out; the shadow keeps the remainder.
                    sdo_o       <= flat[TOT-1];
                    shadow      <= {flat[TOT-2:0], 1'b0};
                    sdo_valid_o <= 1'b1;
                    bitcnt      <= '0;
                    ovf_o       <= |sat;
                    state       <= SHIFT;
                end
                SHIFT: begin
                    if (bitcnt == BW'(TOT - 1)) begin
                        sdo_o       <= 1'b0;
                        sdo_valid_o <= 1'b0;
                        done_o      <= 1'b1;
                        state       <= DONE;
                    end else begin
                        sdo_o  <= shadow[TOT-1];
                        shadow <= {shadow[TOT-2:0], 1'b0};
                        bitcnt <= bitcnt + BW'(1);
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_comp_capture.sv
// Directed bench for comp_capture (N_CH=8, CNT_W=8): counting, saturation, LOAD boundary, control abuse.
module tb_comp_capture;

    localparam int N_CH  = 8;
    localparam int CNT_W = 8;
    localparam int TOT   = N_CH * CNT_W;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N_CH-1:0] comp = '0;
    logic            en = 1'b1;
    logic            start = 1'b0;
    logic            sdo, sdo_valid, busy, done, ovf;

    int checks = 0;
    int errors = 0;

    comp_capture #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .comp_i      (comp),
        .en_i        (en),
        .start_i     (start),
        .sdo_o       (sdo),
        .sdo_valid_o (sdo_valid),
        .busy_o      (busy),
        .done_o      (done),
        .ovf_o       (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulses(input int ch, input int n, input int hi, input int lo);
        for (int p = 0; p < n; p++) begin
            comp[ch] = 1'b1;
            repeat (hi) tick();
            comp[ch] = 1'b0;
            repeat (lo) tick();
        end
    endtask

    // Full readout from start in the current cycle T; poke >= 0 re-pulses start during that bit.
    task automatic readout(input string name, input logic [TOT-1:0] exp,
                           input logic exp_ovf, input int poke);
        logic [TOT-1:0] got;
        bit             vok;
        got = '0;
        vok = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || sdo_valid !== 1'b0 || sdo !== 1'b0) begin
            errors++;
            $display("FAIL %s_load busy=%b valid=%b sdo=%b required 1 0 0", name, busy, sdo_valid, sdo);
        end
        for (int k = 0; k < TOT; k++) begin
            tick();
            start = (k == poke);
            if (sdo_valid !== 1'b1 || done !== 1'b0 || busy !== 1'b1) vok = 1'b0;
            got = {got[TOT-2:0], sdo};
        end
        start = 1'b0;
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || sdo_valid !== 1'b0 || sdo !== 1'b0) begin
            errors++;
            $display("FAIL %s_done done=%b busy=%b valid=%b sdo=%b required 1 1 0 0",
                     name, done, busy, sdo_valid, sdo);
        end
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s_stream got=%h required %h", name, got, exp);
        end
        checks++;
        if (!vok) begin
            errors++;
            $display("FAIL %s_valid sdo_valid/busy dropped or done early during shift", name);
        end
        checks++;
        if (ovf !== exp_ovf) begin
            errors++;
            $display("FAIL %s_ovf got=%b required %b", name, ovf, exp_ovf);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle busy=%b done=%b required 0 0", name, busy, done);
        end
    endtask

    task automatic quiet(input string name, input int cycles);
        int nd;
        nd = 0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) nd++;
        end
        checks++;
        if (nd != 0) begin
            errors++;
            $display("FAIL %s_quiet busy/done cycles=%0d required 0", name, nd);
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if ({sdo, sdo_valid, busy, done, ovf} !== 5'b0) begin
            errors++;
            $display("FAIL reset_state outs=%b required 00000", {sdo, sdo_valid, busy, done, ovf});
        end
        rst = 1'b0;
        pulses(0, 3, 4, 4);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({sdo, sdo_valid, busy, done, ovf} !== 5'b0) begin
            errors++;
            $display("FAIL reset_async outs=%b required 00000", {sdo, sdo_valid, busy, done, ovf});
        end
        tick();
        rst = 1'b0;
        tick();
        readout("reset", '0, 1'b0, -1);
    endtask

    task automatic test_basic();
        pulses(0, 5, 4, 4);
        pulses(7, 3, 4, 4);
        readout("basic", 64'h03000000_00000005, 1'b0, -1);
    endtask

    task automatic test_saturation();
        pulses(2, 300, 2, 2);
        repeat (4) tick();
        readout("sat", 64'h00000000_00FF0000, 1'b1, -1);
        en = 1'b0;
        pulses(5, 3, 4, 4);
        en = 1'b1;
        readout("empty", '0, 1'b0, -1);
    endtask

    task automatic test_boundary();
        int lead;
`ifdef COMP_GLITCH_FILTER_EN
        lead = 2;
`else
        lead = 1;
`endif
        comp[1] = 1'b1;
        repeat (lead) tick();
        readout("bound_snap", '0, 1'b0, -1);
        comp[1] = 1'b0;
        repeat (4) tick();
        readout("bound_next", 64'h00000000_00000100, 1'b0, -1);
    endtask

    task automatic test_start_abuse();
        pulses(4, 2, 4, 4);
        readout("abuse", 64'h00000002_00000000, 1'b0, 10);
        quiet("abuse", 80);
    endtask

    task automatic test_reset_shift();
        pulses(6, 3, 4, 4);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (sdo_valid !== 1'b0 || sdo !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_shift valid=%b sdo=%b busy=%b done=%b required 0 0 0 0",
                     sdo_valid, sdo, busy, done);
        end
        tick();
        rst = 1'b0;
        quiet("rst_shift", 80);
        readout("rst_shift", '0, 1'b0, -1);
    endtask

    task automatic test_glitch();
        logic [TOT-1:0] exp;
`ifdef COMP_GLITCH_FILTER_EN
        exp = '0;
`else
        exp = 64'h00000000_04000000;
`endif
        pulses(3, 4, 1, 4);
        readout("glitch", exp, 1'b0, -1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_boundary();
        test_start_abuse();
        test_reset_shift();
        test_glitch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
